booth_mac_accumulator: RTL and testbench

//  Downstream consumer of the 6x6 signed Booth multiplier's 12-bit product (Z).

---
 rtl/booth_mac_accumulator.sv | 111 +++++++++++
 tb/tb_booth_mac_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_accumulator.sv
// Saturating multiply-accumulate back end: sums N_TERMS signed Booth products into an
// ACC_W-bit result and offers it on a valid/ready port until the consumer takes it.
module booth_mac_accumulator #(
  parameter int PROD_W  = 12,
  parameter int ACC_W   = 20,
  parameter int N_TERMS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf,
  output logic [7:0]        term_cnt
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0]       LAST_CNT = 8'(N_TERMS);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   sat_sum;
  logic               sat_hit;
  logic [7:0]         cnt_inc;

  // One guard bit is enough: the sum overflowed exactly when the top two bits disagree.
  always_comb begin
    sum_ext = {acc_q[ACC_W-1], acc_q}
            + {{(ACC_W+1-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    sat_hit = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    if (sat_hit) begin
      sat_sum = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_sum = sum_ext[ACC_W-1:0];
    end
    cnt_inc = cnt_q + 8'd1;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; clear outranks the handshakes and drops any product offered with it.
  always_comb begin
    // NOTE: hold-current defaults first keep every path assigned, so no latches are inferred.
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (prod_valid) begin
            acc_d = sat_sum;
            ovf_d = ovf_q | sat_hit;
            cnt_d = cnt_inc;
            if (cnt_inc == LAST_CNT) state_d = HOLD;
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // Outputs
  always_comb begin
    prod_ready = (state_q == ACCUM);
    acc_valid  = (state_q == HOLD);
    acc_out    = acc_q;
    ovf        = ovf_q;
    term_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator: three instances (ACC_W=20/N=4, ACC_W=12/N=4,
// ACC_W=20/N=1) share one stimulus stream; each phase checks the instance it targets.
module tb_booth_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst, clear, prod_valid, acc_ready;
  logic [11:0] prod_in;

  logic        a_pr, a_av, a_ovf;
  logic [19:0] a_acc;
  logic [7:0]  a_cnt;
  logic        b_pr, b_av, b_ovf;
  logic [11:0] b_acc;
  logic [7:0]  b_cnt;
  logic        c_pr, c_av, c_ovf;
  logic [19:0] c_acc;
  logic [7:0]  c_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  booth_mac_accumulator #(.PROD_W(12), .ACC_W(20), .N_TERMS(4)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(a_pr), .acc_out(a_acc), .acc_valid(a_av), .acc_ready(acc_ready),
    .ovf(a_ovf), .term_cnt(a_cnt));

  booth_mac_accumulator #(.PROD_W(12), .ACC_W(12), .N_TERMS(4)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(b_pr), .acc_out(b_acc), .acc_valid(b_av), .acc_ready(acc_ready),
    .ovf(b_ovf), .term_cnt(b_cnt));

  booth_mac_accumulator #(.PROD_W(12), .ACC_W(20), .N_TERMS(1)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(c_pr), .acc_out(c_acc), .acc_valid(c_av), .acc_ready(acc_ready),
    .ovf(c_ovf), .term_cnt(c_cnt));

  typedef struct {
    logic clr;
    logic vld;
    int   prod;
    logic ardy;
    int   e_acc;
    logic e_av;
    logic e_pr;
    logic e_ovf;
    int   e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic clr, logic vld, int prod, logic ardy,
                              int e_acc, logic e_av, logic e_pr, logic e_ovf, int e_cnt);
    vec_t v;
    v.clr = clr; v.vld = vld; v.prod = prod; v.ardy = ardy;
    v.e_acc = e_acc; v.e_av = e_av; v.e_pr = e_pr; v.e_ovf = e_ovf; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int acc, input logic av, input logic pr,
                       input logic ovf_e, input int cnt);
    check({tag, " A acc_out"}, $signed(a_acc), acc);
    check({tag, " A acc_valid"}, int'(a_av), int'(av));
    check({tag, " A prod_ready"}, int'(a_pr), int'(pr));
    check({tag, " A ovf"}, int'(a_ovf), int'(ovf_e));
    check({tag, " A term_cnt"}, int'(a_cnt), cnt);
  endtask

  task automatic chk_b(input string tag, input int acc, input logic av, input logic pr,
                       input logic ovf_e, input int cnt);
    check({tag, " B acc_out"}, $signed(b_acc), acc);
    check({tag, " B acc_valid"}, int'(b_av), int'(av));
    check({tag, " B prod_ready"}, int'(b_pr), int'(pr));
    check({tag, " B ovf"}, int'(b_ovf), int'(ovf_e));
    check({tag, " B term_cnt"}, int'(b_cnt), cnt);
  endtask

  task automatic chk_c(input string tag, input int acc, input logic av, input logic pr,
                       input int cnt);
    check({tag, " C acc_out"}, $signed(c_acc), acc);
    check({tag, " C acc_valid"}, int'(c_av), int'(av));
    check({tag, " C prod_ready"}, int'(c_pr), int'(pr));
    check({tag, " C term_cnt"}, int'(c_cnt), cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic clr, input logic vld, input int prod, input logic ardy);
    clear = clr; prod_valid = vld; prod_in = 12'(prod); acc_ready = ardy;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; prod_valid = 1'b0; prod_in = '0; acc_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; prod_valid = 1'b0; prod_in = '0; acc_ready = 1'b0;
    tick();
    tick();
    chk_a("reset", 0, 1'b0, 1'b1, 1'b0, 0);
    chk_b("reset", 0, 1'b0, 1'b1, 1'b0, 0);
    rst = 1'b0;

    // Instance A: back-to-back sum, gapped sum, clear mid-way and clear while holding.
    //            clr  vld  prod  ardy  acc   av   pr   ovf  cnt
    tbl.push_back(mk(0, 1,   30,  0,    30,   0,   1,   0,   1));
    tbl.push_back(mk(0, 1,   30,  0,    60,   0,   1,   0,   2));
    tbl.push_back(mk(0, 1,   30,  0,    90,   0,   1,   0,   3));
    tbl.push_back(mk(0, 1,   30,  0,   120,   1,   0,   0,   4));
    tbl.push_back(mk(0, 1,   99,  0,   120,   1,   0,   0,   4));
    tbl.push_back(mk(0, 0,    0,  1,     0,   0,   1,   0,   0));
    tbl.push_back(mk(0, 1, -992,  0,  -992,   0,   1,   0,   1));
    tbl.push_back(mk(0, 0,  500,  0,  -992,   0,   1,   0,   1));
    tbl.push_back(mk(0, 1, 1024,  0,    32,   0,   1,   0,   2));
    tbl.push_back(mk(0, 0,    0,  0,    32,   0,   1,   0,   2));
    tbl.push_back(mk(0, 0,    0,  1,    32,   0,   1,   0,   2));
    tbl.push_back(mk(0, 1,   -5,  0,    27,   0,   1,   0,   3));
    tbl.push_back(mk(0, 1,    7,  0,    34,   1,   0,   0,   4));
    tbl.push_back(mk(0, 0,    0,  1,     0,   0,   1,   0,   0));
    tbl.push_back(mk(0, 1,   30,  0,    30,   0,   1,   0,   1));
    tbl.push_back(mk(0, 1,   30,  0,    60,   0,   1,   0,   2));
    tbl.push_back(mk(1, 1,   30,  0,     0,   0,   1,   0,   0));
    tbl.push_back(mk(0, 1,   30,  0,    30,   0,   1,   0,   1));
    tbl.push_back(mk(0, 1,   30,  0,    60,   0,   1,   0,   2));
    tbl.push_back(mk(0, 1,   30,  0,    90,   0,   1,   0,   3));
    tbl.push_back(mk(0, 1,   30,  0,   120,   1,   0,   0,   4));
    tbl.push_back(mk(1, 0,    0,  0,     0,   0,   1,   0,   0));
    tbl.push_back(mk(0, 0,    0,  0,     0,   0,   1,   0,   0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].vld, tbl[i].prod, tbl[i].ardy);
      chk_a($sformatf("vec%0d", i), tbl[i].e_acc, tbl[i].e_av, tbl[i].e_pr,
            tbl[i].e_ovf, tbl[i].e_cnt);
    end

    // Instance B (ACC_W=12): positive and negative saturation, sticky ovf, adding onto clamp.
    do_reset();
    drive(0, 1, 1024, 0);  chk_b("satp1", 1024, 0, 1, 0, 1);
    drive(0, 1, 1024, 0);  chk_b("satp2", 2047, 0, 1, 1, 2);
    drive(0, 1, 1024, 0);  chk_b("satp3", 2047, 0, 1, 1, 3);
    drive(0, 1, 1024, 0);  chk_b("satp4", 2047, 1, 0, 1, 4);
    drive(0, 0, 0, 1);     chk_b("satp_take", 0, 0, 1, 0, 0);
    drive(0, 1, -992, 0);  chk_b("satn1", -992, 0, 1, 0, 1);
    drive(0, 1, -992, 0);  chk_b("satn2", -1984, 0, 1, 0, 2);
    drive(0, 1, -992, 0);  chk_b("satn3", -2048, 0, 1, 1, 3);
    drive(0, 1, -992, 0);  chk_b("satn4", -2048, 1, 0, 1, 4);
    drive(0, 0, 0, 1);     chk_b("satn_take", 0, 0, 1, 0, 0);
    drive(0, 1, 1024, 0);
    drive(0, 1, 1024, 0);  chk_b("onto_sat2", 2047, 0, 1, 1, 2);
    drive(0, 1, -1000, 0); chk_b("onto_sat3", 1047, 0, 1, 1, 3);
    drive(0, 1, -1047, 0); chk_b("onto_sat4", 0, 1, 0, 1, 4);

    // Instance A: long HOLD with prod_valid high, then consume with a product offered.
    do_reset();
    for (int i = 0; i < 4; i++) drive(0, 1, 30, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 55, 0);
      chk_a($sformatf("hold%0d", i), 120, 1, 0, 0, 4);
    end
    drive(0, 1, 55, 1);    chk_a("handoff", 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0);     chk_a("after_handoff", 0, 0, 1, 0, 0);

    // Reset mid-accumulation (B saturated) and reset during HOLD.
    do_reset();
    drive(0, 1, 1024, 0);
    drive(0, 1, 1024, 0);
    chk_a("pre_rst", 2048, 0, 1, 0, 2);
    chk_b("pre_rst", 2047, 0, 1, 1, 2);
    rst = 1'b1;
    drive(0, 1, 30, 0);
    chk_a("rst_mid", 0, 0, 1, 0, 0);
    chk_b("rst_mid", 0, 0, 1, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(0, 1, 30, 0);
    chk_a("pre_rst_hold", 120, 1, 0, 0, 4);
    rst = 1'b1;
    drive(0, 1, 30, 0);
    chk_a("rst_hold", 0, 0, 1, 0, 0);
    rst = 1'b0;

    // Instance C (N_TERMS=1): each accept completes a result.
    do_reset();
    drive(0, 1, -7, 0);    chk_c("n1_acc", -7, 1, 0, 1);
    drive(0, 1, 5, 0);     chk_c("n1_hold", -7, 1, 0, 1);
    drive(0, 1, 5, 1);     chk_c("n1_take", 0, 0, 1, 0);
    drive(0, 1, 5, 0);     chk_c("n1_acc2", 5, 1, 0, 1);
    drive(1, 1, 9, 0);     chk_c("n1_clear", 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
